pcie_to_pc_fifo: RTL and testbench



---
 rtl/pcie_to_pc_fifo.sv | 145 ++++++++++++++
 tb/tb_pcie_to_pc_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_to_pc_fifo.sv
// Card-to-host DMA FIFO. User logic pushes 64-bit words into a BRAM ring;
// every time a full block is buffered and the host limit pointer allows it,
// one memory-write burst is issued to a host page translated through a
// 32-entry page table.
module pcie_to_pc_fifo #(
  parameter int BLOCK_WORDS = 16,
  parameter int DEPTH_LOG2  = 9
) (
  input  logic        clock,
  input  logic        reset,
  output logic [1:0]  interrupt,
  output logic [63:0] status,
  input  logic        pio_wvalid,
  input  logic [63:0] pio_wdata,
  input  logic [12:0] pio_addr,
  input  logic        fifo_write,
  input  logic [63:0] fifo_write_data,
  output logic        fifo_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [63:0] wr_addr,
  output logic [63:0] wr_data,
  output logic        wr_last
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int BLK_W = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_BURST} state_t;

  state_t           state_q;
  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] rp_q;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] rd_addr_d;
  logic [18:0]      p_sent_q;
  logic [18:0]      p_stop_q;
  logic [18:0]      p_int_q;
  logic [42:0]      pt_q [32];
  logic [63:0]      mem_q [1 << DEPTH_LOG2];
  logic [63:0]      rd_data_q;
  logic [63:0]      wr_addr_q;
  logic             wr_valid_q;
  logic             wr_last_q;
  logic [1:0]       interrupt_q;
  logic             wr_en;
  logic             beat_acc;
  logic [9:0]       count_st;
  logic             unused_ok;

  // Fill count is the modular pointer difference; the extra pointer bit
  // distinguishes a full ring (count == depth) from an empty one.
  assign count      = wp_q - rp_q;
  assign fifo_ready = ~count[PTR_W-1];
  assign wr_en      = fifo_write & fifo_ready;
  assign beat_acc   = wr_valid_q & wr_ready;
  assign count_st   = 10'(count);

  // The read port always fetches the word that will be on the bus next
  // cycle: rp+1 after an accepted beat, otherwise rp again, so the output
  // register holds its word under stall and advances with no bubble.
  assign rd_addr_d = beat_acc ? rp_q + PTR_W'(1) : rp_q;

  assign wr_valid  = wr_valid_q;
  assign wr_last   = wr_last_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = rd_data_q;
  assign interrupt = interrupt_q;
  assign status    = {22'd0, count_st, 6'd0, p_sent_q, 7'd0};
  assign unused_ok = ^pio_wdata[6:0];

  // Buffer storage and its registered read port (the beat prefetch register).
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wp_q[DEPTH_LOG2-1:0]] <= fifo_write_data;
    rd_data_q <= mem_q[rd_addr_d[DEPTH_LOG2-1:0]];
  end

  // Page table loads from PIO; contents survive reset.
  always_ff @(posedge clock) begin
    if (pio_wvalid && pio_addr[12:5] == 8'd2) pt_q[pio_addr[4:0]] <= pio_wdata[63:21];
  end

  // Host-owned limit and interrupt-threshold block pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_stop_q <= '0;
      p_int_q  <= '0;
    end else if (pio_wvalid) begin
      if (pio_addr == 13'd6) p_stop_q <= pio_wdata[25:7];
      if (pio_addr == 13'd7) p_int_q  <= pio_wdata[25:7];
    end
  end

  // User write pointer; writes while full are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wp_q <= '0;
    else if (wr_en) wp_q <= wp_q + PTR_W'(1);
  end

  // Interrupt levels compare the completed-block count with both thresholds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) interrupt_q <= 2'b00;
    else interrupt_q <= {(p_stop_q == p_sent_q), (p_int_q == p_sent_q)};
  end

  // Burst sequencer: wait for a full block and host credit, prime the read
  // port for one cycle, then stream BLOCK_WORDS beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rp_q       <= '0;
      p_sent_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_last_q  <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count >= PTR_W'(BLOCK_WORDS) && p_sent_q != p_stop_q) state_q <= S_PREP;
        end
        S_PREP: begin
          state_q    <= S_BURST;
          wr_valid_q <= 1'b1;
          wr_last_q  <= 1'b0;
          wr_addr_q  <= {pt_q[p_sent_q[18:14]], p_sent_q[13:0], 7'd0};
        end
        S_BURST: begin
          if (beat_acc) begin
            rp_q <= rp_q + PTR_W'(1);
            if (wr_last_q) begin
              wr_valid_q <= 1'b0;
              wr_last_q  <= 1'b0;
              p_sent_q   <= p_sent_q + 19'd1;
              state_q    <= S_IDLE;
            end else begin
              wr_last_q <= (rp_q[BLK_W-1:0] == BLK_W'(BLOCK_WORDS - 2));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_to_pc_fifo.sv
// Bench for pcie_to_pc_fifo: PIO decode table plus burst scenarios checked
// against a scoreboard of written words and a block-address model.
module tb_pcie_to_pc_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  interrupt;
  logic [63:0] status;
  logic        pio_wvalid = 1'b0;
  logic [63:0] pio_wdata = '0;
  logic [12:0] pio_addr = '0;
  logic        fifo_write = 1'b0;
  logic [63:0] fifo_write_data = '0;
  logic        fifo_ready;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [63:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_last;

  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  int          beat = 0;
  logic [18:0] exp_blk = '0;
  logic [63:0] exp_q[$];
  logic [42:0] pt_model [32];
  bit          held_v = 1'b0;
  logic [63:0] held_d;
  logic [63:0] held_a;
  bit          valid_seen = 1'b0;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
    logic [1:0]  exp_int;
  } vec_t;

  pcie_to_pc_fifo dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .status(status),
    .pio_wvalid(pio_wvalid), .pio_wdata(pio_wdata), .pio_addr(pio_addr),
    .fifo_write(fifo_write), .fifo_write_data(fifo_write_data),
    .fifo_ready(fifo_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pio_wr(input logic [12:0] a, input logic [63:0] d);
    pio_addr = a; pio_wdata = d; pio_wvalid = 1'b1;
    @(posedge clock); #1;
    pio_wvalid = 1'b0;
  endtask

  task automatic write_word(input logic [63:0] d, input bit accepted);
    fifo_write = 1'b1; fifo_write_data = d;
    if (accepted) exp_q.push_back(d);
    @(posedge clock); #1;
    fifo_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_acc(input int target, input bit toggle, input int budget, input string name);
    int c = 0;
    while (acc_cnt < target && c < budget) begin
      @(posedge clock); #1;
      if (toggle) wr_ready = ~wr_ready;
      c++;
    end
    total++;
    if (acc_cnt < target) begin
      bad++;
      $display("FAIL %s: timeout with %0d beats, needed %0d", name, acc_cnt, target);
    end
    wr_ready = 1'b1;
  endtask

  // Scoreboard: every accepted beat must be the oldest written word, at the
  // modelled block address, with wr_last only on the final beat.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      exp_blk = '0;
      beat = 0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 64'(wr_valid), 64'd1);
        chk("hold_data", wr_data, held_d);
        chk("hold_addr", wr_addr, held_a);
      end
      held_v = 1'b0;
      if (wr_valid) begin
        valid_seen = 1'b1;
        if (wr_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL beat_extra: got data %h want no beat", wr_data);
          end else begin
            chk("beat_data", wr_data, exp_q.pop_front());
            chk("beat_addr", wr_addr, {pt_model[exp_blk[18:14]], exp_blk[13:0], 7'd0});
            chk("beat_last", 64'(wr_last), 64'(beat == 15));
            beat++;
            if (beat == 16) begin
              beat = 0;
              exp_blk = exp_blk + 19'd1;
            end
          end
        end else begin
          held_v = 1'b1;
          held_d = wr_data;
          held_a = wr_addr;
        end
      end
    end
  end

  initial begin
    vec_t tbl [11];
    int   acc0;
    tbl[0]  = '{13'd6,    64'h1000,      2'b01};
    tbl[1]  = '{13'd7,    64'h100,       2'b00};
    tbl[2]  = '{13'd7,    64'h0,         2'b01};
    tbl[3]  = '{13'd6,    64'h0,         2'b11};
    tbl[4]  = '{13'd5,    64'hFFFF_FFFF, 2'b11};
    tbl[5]  = '{13'd8,    64'hFFFF_FFFF, 2'b11};
    tbl[6]  = '{13'd6,    64'h7F,        2'b11};
    tbl[7]  = '{13'd6,    64'h80,        2'b01};
    tbl[8]  = '{13'h1006, 64'h0,         2'b01};
    tbl[9]  = '{13'd6,    64'h1000,      2'b01};
    tbl[10] = '{13'd7,    64'h100,       2'b00};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_last", 64'(wr_last), 64'd0);
    chk("rst_interrupt", 64'(interrupt), 64'd0);
    chk("rst_fifo_ready", 64'(fifo_ready), 64'd1);
    chk("rst_status", status, 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("int_after_rst", 64'(interrupt), 64'd3);
    @(posedge clock); #1;

    // PIO decode vectors, observed through the interrupt levels
    for (int i = 0; i < 11; i++) begin
      pio_wr(tbl[i].addr, tbl[i].data);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("pio_vec%0d_int", i), 64'(interrupt), 64'(tbl[i].exp_int));
      chk($sformatf("pio_vec%0d_status", i), status, 64'd0);
      @(posedge clock); #1;
    end

    pio_wr(13'd64, 64'h123 << 21); pt_model[0] = 43'h123;
    pio_wr(13'd65, 64'h456 << 21); pt_model[1] = 43'h456;

    // Basic 16-word burst to pt[0] at offset 0
    for (int i = 0; i < 16; i++) write_word(64'(i), 1'b1);
    wait_acc(16, 1'b0, 60, "burst1_done");
    @(negedge clock);
    chk("burst1_status", status, 64'h80);
    chk("burst1_q_empty", 64'(exp_q.size()), 64'd0);
    chk("burst1_int", 64'(interrupt), 64'd0);
    @(posedge clock); #1;

    // Second burst with wr_ready toggling; interrupt[0] follows one cycle later
    for (int i = 16; i < 32; i++) write_word(64'(i), 1'b1);
    wait_acc(32, 1'b1, 100, "burst2_done");
    @(negedge clock);
    chk("int0_before", 64'(interrupt[0]), 64'd0);
    @(negedge clock);
    chk("int0_after", 64'(interrupt[0]), 64'd1);
    chk("int1_low", 64'(interrupt[1]), 64'd0);
    chk("burst2_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clock); #1;

    // Fill the whole ring while the host limit blocks bursts
    do_reset();
    valid_seen = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 512; i++) write_word(64'hA500_0000_0000_0000 + 64'(i), 1'b1);
    @(negedge clock);
    chk("full_ready", 64'(fifo_ready), 64'd0);
    chk("full_status", status, 64'h0000_0200_0000_0000);
    @(posedge clock); #1;
    write_word(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    chk("full_drop_status", status, 64'h0000_0200_0000_0000);
    chk("full_no_valid", 64'(valid_seen), 64'd0);
    pio_wr(13'd6, 64'h1000);
    wait_acc(acc0 + 512, 1'b0, 1500, "drain_done");
    @(negedge clock);
    chk("drain_status", status, 64'h1000);
    chk("drain_ready", 64'(fifo_ready), 64'd1);
    chk("drain_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    chk("drain_int", 64'(interrupt), 64'd2);
    repeat (5) @(negedge clock);
    chk("drain_no_more", 64'(acc_cnt), 64'(acc0 + 512));
    @(posedge clock); #1;

    // Reset in the middle of a burst
    do_reset();
    pio_wr(13'd6, 64'h1000);
    acc0 = acc_cnt;
    for (int i = 0; i < 16; i++) write_word(64'h5A00 + 64'(i), 1'b1);
    wait_acc(acc0 + 7, 1'b0, 40, "mid_beats");
    chk("mid_valid", 64'(wr_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(wr_valid), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_status", status, 64'd0);
    chk("mid_rst_ready", 64'(fifo_ready), 64'd1);
    chk("mid_rst_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clock); #1;
    pio_wr(13'd6, 64'h1000);
    acc0 = acc_cnt;
    for (int i = 0; i < 16; i++) write_word(64'hC0DE_0000 + 64'(i), 1'b1);
    wait_acc(acc0 + 16, 1'b0, 60, "fresh_burst");
    @(negedge clock);
    chk("fresh_status", status, 64'h80);
    chk("fresh_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
